// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane enable helper.
package ahb_pkg;
  localparam logic       HTRANS_IDLE   = 1'b0;
  localparam logic       HTRANS_NONSEQ = 1'b1;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2, ST_SLEEP
  } state_e;

  // Little-endian lane select for a 32-bit bus.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << a;
      HSIZE_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: byte_en = 4'b1111;
      default:    byte_en = 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/ahb_wait_counter.sv
// Loadable down-counter; o_zero marks the last wait cycle of a data phase.
module ahb_wait_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn)                    r_cnt <= '0;
    else if (i_load)                r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite responder with a small word memory, programmable wait states,
// two-cycle ERROR response and a sleep req/ack handshake.
module ahb_sram_responder
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_hselx,
  input  logic                  i_htrans,
  input  logic [2:0]            i_hsize,
  input  logic                  i_hwrite,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata,
  input  logic                  i_sleep_req,
  output logic                  o_sleep_ack
);
  localparam int                    AW    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [2:0]            WLOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                r_state, w_nxt;
  logic [AW-1:0]         r_idx;
  logic [3:0]            r_be;
  logic                  r_write, r_asleep, r_hreadyout, r_hresp, r_sleep_ack;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_acc, w_err, w_zero, w_wr;

  assign w_acc = i_hselx & i_htrans & i_hready & r_hreadyout;
  // r_asleep also covers the ERR1/ERR2 detour taken while sleeping.
  assign w_err = (i_haddr >= LIMIT) | (i_hsize > HSIZE_WORD)
               | ((i_hsize == HSIZE_HALF) & i_haddr[0])
               | ((i_hsize == HSIZE_WORD) & (i_haddr[1:0] != 2'b00))
               | r_asleep;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_WAIT: if (w_zero) w_nxt = ST_DATA;
      ST_ERR1: w_nxt = ST_ERR2;
      default: if (i_hready) begin
        if (w_acc)                        w_nxt = w_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);
        else if (r_state == ST_SLEEP)     w_nxt = i_sleep_req ? ST_SLEEP : ST_IDLE;
        else if (r_asleep || i_sleep_req) w_nxt = ST_SLEEP;
        else                              w_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_sleep_ack <= 1'b0;
      r_asleep    <= 1'b0;
      r_idx       <= '0;
      r_be        <= '0;
      r_write     <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_hreadyout <= !(w_nxt == ST_WAIT || w_nxt == ST_ERR1);
      r_hresp     <= (w_nxt == ST_ERR1 || w_nxt == ST_ERR2);
      if (w_nxt == ST_SLEEP)     r_asleep <= 1'b1;
      else if (w_nxt == ST_IDLE) r_asleep <= 1'b0;
      if (r_state == ST_SLEEP && i_hready) r_sleep_ack <= i_sleep_req;
      if (w_acc) begin
        r_idx   <= i_haddr[2 +: AW];
        r_be    <= byte_en(i_hsize, i_haddr[1:0]);
        r_write <= i_hwrite;
      end
    end
  end

  ahb_wait_counter #(.W(3)) u_wait (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     ((w_nxt == ST_WAIT) && (r_state != ST_WAIT)),
    .i_load_val (WLOAD),
    .i_dec      (r_state == ST_WAIT),
    .o_zero     (w_zero)
  );

  // Write commits at the edge closing DATA, so a following read sees it without forwarding.
  assign w_wr = (r_state == ST_DATA) & r_write & i_hready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
    end
  end

  assign o_hrdata    = (r_state == ST_DATA && !r_write) ? r_mem[r_idx] : '0;
  assign o_hreadyout = r_hreadyout;
  assign o_hresp     = r_hresp;
  assign o_sleep_ack = r_sleep_ack;
endmodule

// File: tb/tb_ahb_sram_responder.sv
// Bench for ahb_sram_responder: one instance with one wait state, one with none.
module tb_ahb_sram_responder;
  import ahb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rstn, hsel, htrans, hwrite, hready, sreq, hro, hresp, ack;
  logic [1:0][2:0]  hsize;
  logic [1:0][31:0] haddr, hwdata, hrdata;

  ahb_sram_responder #(.WAIT_STATES(1)) u_ws1 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_hselx(hsel[0]), .i_htrans(htrans[0]),
    .i_hsize(hsize[0]), .i_hwrite(hwrite[0]), .i_haddr(haddr[0]), .i_hwdata(hwdata[0]),
    .i_hready(hready[0]), .o_hreadyout(hro[0]), .o_hresp(hresp[0]), .o_hrdata(hrdata[0]),
    .i_sleep_req(sreq[0]), .o_sleep_ack(ack[0]));

  ahb_sram_responder #(.WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_hselx(hsel[1]), .i_htrans(htrans[1]),
    .i_hsize(hsize[1]), .i_hwrite(hwrite[1]), .i_haddr(haddr[1]), .i_hwdata(hwdata[1]),
    .i_hready(hready[1]), .o_hreadyout(hro[1]), .o_hresp(hresp[1]), .o_hrdata(hrdata[1]),
    .i_sleep_req(sreq[1]), .o_sleep_ack(ack[1]));

  typedef struct {
    int          d;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    bit          resp;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
      e = '{1'b0, 0, 32'h0};
    end else e = sb.pop_front();
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single non-pipelined transfer; starts and ends just after a falling edge.
  task automatic xfer(input int d, input bit wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input string tag);
    exp_t e;
    int   waits = 0;
    bit   wresp = 1'b0;
    hsel[d] = 1'b1; htrans[d] = 1'b1; hwrite[d] = wr; hsize[d] = sz; haddr[d] = a;
    cyc();
    hsel[d] = 1'b0; htrans[d] = 1'b0; hwdata[d] = wd;
    while (hro[d] !== 1'b1 && waits < 10) begin
      wresp = wresp | hresp[d];
      waits++;
      cyc();
    end
    pop_exp(tag, e);
    chk({tag, " waits"}, 32'(waits), 32'(e.waits));
    if (waits > 0) chk({tag, " wait-phase resp"}, 32'(wresp), 32'(e.resp));
    chk({tag, " resp"}, 32'(hresp[d]), 32'(e.resp));
    chk({tag, " rdata"}, hrdata[d], e.rdata);
    cyc();
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, " hreadyout"}, 32'(hro[d]), 32'h1);
    chk({tag, " hresp"}, 32'(hresp[d]), 32'h0);
    chk({tag, " hrdata"}, hrdata[d], 32'h0);
    chk({tag, " sleep_ack"}, 32'(ack[d]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rstn = '0; hsel = '0; htrans = '0; hwrite = '0; hsize = '0;
    haddr = '0; hwdata = '0; hready = 2'b11; sreq = '0;

    //        d wr size        addr   wdata         err rdata
    vt.push_back('{0, 1, HSIZE_WORD, 32'h04, 32'hAAAA5555, 0, 32'h0});
    vt.push_back('{0, 0, HSIZE_WORD, 32'h04, 32'h0,        0, 32'hAAAA5555});
    vt.push_back('{0, 1, HSIZE_WORD, 32'h04, 32'h11111111, 0, 32'h0});
    vt.push_back('{0, 1, HSIZE_BYTE, 32'h05, 32'h22222222, 0, 32'h0});
    vt.push_back('{0, 0, HSIZE_WORD, 32'h04, 32'h0,        0, 32'h11112211});
    vt.push_back('{0, 1, HSIZE_HALF, 32'h07, 32'hFFFFFFFF, 1, 32'h0});
    vt.push_back('{0, 0, HSIZE_WORD, 32'h04, 32'h0,        0, 32'h11112211});
    vt.push_back('{0, 0, HSIZE_WORD, 32'h40, 32'h0,        1, 32'h0});
    vt.push_back('{0, 0, 3'b011,     32'h08, 32'h0,        1, 32'h0});
    vt.push_back('{0, 1, HSIZE_HALF, 32'h06, 32'h33334444, 0, 32'h0});
    vt.push_back('{0, 0, HSIZE_WORD, 32'h04, 32'h0,        0, 32'h33332211});
    vt.push_back('{0, 1, HSIZE_WORD, 32'h3C, 32'hCAFEF00D, 0, 32'h0});
    vt.push_back('{0, 0, HSIZE_WORD, 32'h3C, 32'h0,        0, 32'hCAFEF00D});
    vt.push_back('{0, 0, HSIZE_WORD, 32'h02, 32'h0,        1, 32'h0});
    vt.push_back('{0, 0, HSIZE_BYTE, 32'h3F, 32'h0,        0, 32'hCAFEF00D});
    vt.push_back('{1, 1, HSIZE_WORD, 32'h10, 32'h12345678, 0, 32'h0});
    vt.push_back('{1, 0, HSIZE_WORD, 32'h10, 32'h0,        0, 32'h12345678});
    vt.push_back('{1, 0, HSIZE_WORD, 32'h44, 32'h0,        1, 32'h0});

    repeat (3) cyc();
    chk_reset(0, "reset ws1");
    chk_reset(1, "reset ws0");
    rstn = 2'b11;
    cyc();

    foreach (vt[i]) begin
      e.resp  = vt[i].err;
      e.waits = vt[i].err ? 1 : ((vt[i].d == 0) ? 1 : 0);
      e.rdata = vt[i].rdata;
      sb.push_back(e);
      xfer(vt[i].d, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, $sformatf("vec%0d", i));
    end

    // Pipelined writes to 0x8, 0xC then a read of 0x8 on the zero-wait instance.
    hsel[1] = 1'b1; htrans[1] = 1'b1; hwrite[1] = 1'b1; hsize[1] = HSIZE_WORD; haddr[1] = 32'h8;
    cyc();
    chk("pipe w0 hreadyout", 32'(hro[1]), 32'h1);
    hwdata[1] = 32'h08080808; haddr[1] = 32'hC;
    cyc();
    chk("pipe w1 hreadyout", 32'(hro[1]), 32'h1);
    hwdata[1] = 32'h0C0C0C0C; hwrite[1] = 1'b0; haddr[1] = 32'h8;
    sb.push_back('{1'b0, 0, 32'h08080808});
    cyc();
    hsel[1] = 1'b0; htrans[1] = 1'b0;
    pop_exp("pipe rd", e);
    chk("pipe rd hreadyout", 32'(hro[1]), 32'(e.waits == 0));
    chk("pipe rd resp", 32'(hresp[1]), 32'(e.resp));
    chk("pipe rd rdata", hrdata[1], e.rdata);
    cyc();
    sb.push_back('{1'b0, 0, 32'h0C0C0C0C});
    xfer(1, 1'b0, HSIZE_WORD, 32'hC, 32'h0, "pipe rd2");

    // Selected with bus HREADY low: must not be accepted.
    hready[0] = 1'b0; hsel[0] = 1'b1; htrans[0] = 1'b1; hwrite[0] = 1'b0;
    hsize[0] = HSIZE_WORD; haddr[0] = 32'h4;
    cyc();
    chk("no-hready hreadyout", 32'(hro[0]), 32'h1);
    chk("no-hready rdata", hrdata[0], 32'h0);
    hready[0] = 1'b1; hsel[0] = 1'b0; htrans[0] = 1'b0;
    cyc();
    chk("no-hready after hreadyout", 32'(hro[0]), 32'h1);

    // Sleep handshake.
    sreq[0] = 1'b1;
    cyc();
    chk("sleep ack entry cycle", 32'(ack[0]), 32'h0);
    cyc();
    chk("sleep ack raised", 32'(ack[0]), 32'h1);
    sb.push_back('{1'b1, 1, 32'h0});
    xfer(0, 1'b0, HSIZE_WORD, 32'h4, 32'h0, "sleep xfer");
    chk("sleep ack held", 32'(ack[0]), 32'h1);
    sreq[0] = 1'b0;
    cyc();
    chk("sleep ack cleared", 32'(ack[0]), 32'h0);
    sb.push_back('{1'b0, 1, 32'h0});
    xfer(0, 1'b1, HSIZE_WORD, 32'h8, 32'h5A5A5A5A, "wake wr");
    sb.push_back('{1'b0, 1, 32'h5A5A5A5A});
    xfer(0, 1'b0, HSIZE_WORD, 32'h8, 32'h0, "wake rd");

    // Reset in the wait cycle of a write to 0x0.
    hsel[0] = 1'b1; htrans[0] = 1'b1; hwrite[0] = 1'b1; hsize[0] = HSIZE_WORD; haddr[0] = 32'h0;
    cyc();
    chk("rst-mid wait hreadyout", 32'(hro[0]), 32'h0);
    hsel[0] = 1'b0; htrans[0] = 1'b0; hwdata[0] = 32'hDEADBEEF; rstn[0] = 1'b0;
    cyc();
    chk_reset(0, "rst-mid");
    rstn[0] = 1'b1;
    cyc();
    sb.push_back('{1'b0, 1, 32'h0});
    xfer(0, 1'b0, HSIZE_WORD, 32'h0, 32'h0, "rst-mid rd0");
    sb.push_back('{1'b0, 1, 32'h0});
    xfer(0, 1'b0, HSIZE_WORD, 32'h8, 32'h0, "rst-mid rd8");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
- AHB-Lite slave (responder) answering the sink-side master port of the AHB-AHB bridge; owns a small word-addressed register memory.
- Sits on the sink clock domain as the bridge's downstream target. Also serves as the standard end-point model for bridge-level benches.
- Supports programmable wait states, byte/halfword/word writes, a two-cycle ERROR response, and the codebase sleep req/ack handshake.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, address bus width.
- DEPTH, 16, number of 32-bit words; power of two, at least 2.
- WAIT_STATES, 1, wait cycles inserted in every OKAY data phase; range 0..7.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous active-low reset.
- i_hselx  in  1  slave select.
- i_htrans  in  1  1 = NONSEQ, 0 = IDLE.
- i_hsize  in  3  transfer size.
- i_hwrite  in  1  1 = write.
- i_haddr  in  ADDR_WIDTH  byte address.
- i_hwdata  in  DATA_WIDTH  write data; valid in the data phase.
- i_hready  in  1  bus HREADY; address phase is sampled only when this is high.
- o_hreadyout  out  1  slave ready.
- o_hresp  out  1  0 = OKAY, 1 = ERROR.
- o_hrdata  out  DATA_WIDTH  read data.
- i_sleep_req  in  1  sleep request.
- o_sleep_ack  out  1  sleep acknowledge.

Behaviour:
- One clock, i_clk. Reset i_rstn is synchronous, active-low.
- Reset values: o_hreadyout=1, o_hresp=0, o_hrdata=0, o_sleep_ack=0, FSM=IDLE, all memory words=0.
- Reset mid-transfer aborts the transfer; no memory write occurs.
- Accept condition: i_hselx & i_htrans & i_hready & o_hreadyout, sampled on the rising edge.
- On accept, register addr, size, write into the data-phase registers.
- Error check at accept. The transfer is an error if any of:
  - addr >= DEPTH*4;
  - hsize > 3'b010;
  - hsize=001 with addr[0]=1;
  - hsize=010 with addr[1:0]!=0;
  - FSM is SLEEP.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2, SLEEP.
- IDLE:
  - o_hreadyout=1.
  - Accept with error -> ERR1.
  - Accept OK with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - Accept OK with WAIT_STATES=0 -> DATA.
  - No accept and i_sleep_req=1 -> SLEEP.
- WAIT: o_hreadyout=0, o_hresp=0. Counter decrements; at 0 -> DATA.
- DATA: o_hreadyout=1, o_hresp=0.
  - Read: o_hrdata = mem[addr_q[2+:log2(DEPTH)]].
  - Write: i_hwdata is written at the edge ending this cycle, with byte enables from size and addr_q[1:0] (byte: lane addr[1:0]; halfword: lanes {addr[1],0} and {addr[1],1}; word: all lanes).
  - Same edge may accept the next transfer (pipelined), following the IDLE rules, including sleep.
- ERR1: o_hreadyout=0, o_hresp=1 -> ERR2.
- ERR2: o_hreadyout=1, o_hresp=1. No memory update. May accept the next transfer, as in IDLE.
- o_hrdata is 0 whenever it is not a read in DATA.
- Read-after-write to the same word with WAIT_STATES=0 returns the new data. The write commits before the read's data phase, so no forwarding is required.
- Sleep:
  - An accept in the same cycle as i_sleep_req wins; sleep is entered only from an IDLE or ERR2/DATA cycle with no accept.
  - o_sleep_ack=1 is registered: it rises the cycle after SLEEP is entered.
  - In SLEEP, accepted transfers get ERR1/ERR2 and then return to SLEEP.
  - i_sleep_req=0 -> IDLE; o_sleep_ack clears on the same edge.
- i_hready=0 while o_hreadyout=1: no sampling; state is held.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/HTRANS_NONSEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/ERROR;
  - FSM state encoding;
  - a function that returns the 4-bit byte-enable from hsize and addr[1:0].
- One sub-module is natural: ahb_wait_counter, a loadable down-counter with a zero flag that drives WAIT exit.
- Memory stays inline.

Test Plan:
- Word write then read, WAIT_STATES=1: write 0x4 data 0xAAAA5555, then read 0x4 -> one cycle with hreadyout=0, then hrdata=0xAAAA5555 with hresp=0.
- Byte write 0x22 to addr 0x5 over word 0x11111111 at 0x4, then read 0x4 -> 0x11112211. Halfword write to 0x7 -> ERROR (ERR1: hreadyout=0, hresp=1; ERR2: hreadyout=1, hresp=1); memory unchanged.
- Address 0x40 (DEPTH=16) read -> two-cycle ERROR, hrdata=0. hsize=3'b011 -> ERROR.
- WAIT_STATES=0: back-to-back writes to 0x8, 0xC followed by a read of 0x8 -> zero wait states, read returns the first write's data. i_hready=0 with hselx=1 -> no accept.
- i_sleep_req=1 while idle -> o_sleep_ack=1 one cycle later. A transfer while asleep -> ERROR and ack stays 1. Deassert req -> ack=0 next cycle, and a normal OKAY transfer follows.
- i_rstn=0 during WAIT of a write to 0x0 -> outputs return to reset values next cycle; a read of 0x0 after reset returns 0.
